hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed-stage hazard control unit of the 5-stage MIPS pipeline.
- Holds an in-flight write scoreboard of NUM_STAGES entries (E, M, W, ...) with per-entry Tnew countdown, and owns the multiply/divide busy counter.
- Produces D-stage stall/E-flush, D-stage forward selects for every source operand, and a stall watchdog.
- Sits beside the D stage; decode supplies pre-decoded Tuse/Tnew/write info, so the unit needs no opcode knowledge.

---
 rtl/hazard_scoreboard.sv | 157 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit that sits beside the D stage of an in-order pipeline. It keeps
// a scoreboard of in-flight GPR writes (entry 0 = E, 1 = M, 2 = W, ...), each
// entry holding the time left until the result exists (Tnew). The unit also
// owns the multiply/divide busy counter and a stall watchdog. Decode hands in
// pre-decoded Tuse/Tnew/write information, so no opcode knowledge lives here.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   flush          exception/eret flush of E and later stages
//   d_valid        D holds a real instruction
//   d_src_addr     packed source registers, operand i at [i*REG_AW +: REG_AW]
//   d_src_use      operand i is actually read
//   d_src_tuse     packed Tuse per operand (cycles from D until needed)
//   d_wr_en        D instruction writes the GRF
//   d_wr_addr      D destination register
//   d_tnew         Tnew of the D instruction on entry to E
//   d_md_op        any mult/div/mfhi/mflo/mthi/mtlo in D
//   d_md_start     mult/multu/div/divu in D
//   d_md_div       qualifies d_md_start as a divide
//   stall          freeze PC and F/D
//   e_flush        bubble into E (same as stall)
//   fwd_sel        3 bits per operand: 0 = GRF, k = result from stage k-1
//   md_busy        MDU counter nonzero
//   stall_timeout  sticky: stall held for STALL_LIMIT consecutive cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW      = 5,
    parameter int NUM_STAGES  = 3,
    parameter int NUM_SRC     = 2,
    parameter int TW          = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int STALL_LIMIT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      d_valid,
    input  logic [NUM_SRC*REG_AW-1:0] d_src_addr,
    input  logic [NUM_SRC-1:0]        d_src_use,
    input  logic [NUM_SRC*TW-1:0]     d_src_tuse,
    input  logic                      d_wr_en,
    input  logic [REG_AW-1:0]         d_wr_addr,
    input  logic [TW-1:0]             d_tnew,
    input  logic                      d_md_op,
    input  logic                      d_md_start,
    input  logic                      d_md_div,
    output logic                      stall,
    output logic                      e_flush,
    output logic [NUM_SRC*3-1:0]      fwd_sel,
    output logic                      md_busy,
    output logic                      stall_timeout
);

    localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int MDW    = $clog2(MD_MAX + 1);
    localparam int SCW    = $clog2(STALL_LIMIT + 1);

    // Scoreboard entries, index 0 is the youngest (E stage).
    logic [NUM_STAGES-1:0] ent_valid;
    logic [REG_AW-1:0]     ent_addr [NUM_STAGES];
    logic [TW-1:0]         ent_tnew [NUM_STAGES];

    logic [MDW-1:0]        md_cnt;
    logic [SCW-1:0]        stall_cnt;
    logic                  timeout_q;
    logic [NUM_SRC-1:0]    src_hazard;
    logic                  md_hazard;
    logic                  md_issue;

    // -----------------------------------------------------------------------
    // Per-operand match, forward select and hazard detection
    // -----------------------------------------------------------------------
    // Entries are scanned oldest to youngest so a younger match overwrites an
    // older one; the youngest writer is always the architecturally live value.
    // NOTE: every output of this block gets a default before the loops, so no
    // path leaves a bit unassigned and no latch is inferred.
    always_comb begin
        src_hazard = '0;
        fwd_sel    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (ent_valid[k] && d_valid && d_src_use[i] &&
                    (d_src_addr[i*REG_AW +: REG_AW] != '0) &&
                    (ent_addr[k] == d_src_addr[i*REG_AW +: REG_AW])) begin
                    if (ent_tnew[k] == '0) begin
                        fwd_sel[i*3 +: 3] = 3'(k + 1);
                        src_hazard[i]     = 1'b0;
                    end else begin
                        // Result not ready yet: either stall now or let a
                        // later stage forward it once Tnew reaches zero.
                        fwd_sel[i*3 +: 3] = 3'd0;
                        src_hazard[i]     = (d_src_tuse[i*TW +: TW] < ent_tnew[k]);
                    end
                end
            end
        end
    end

    assign md_busy       = (md_cnt != '0);
    assign md_hazard     = d_valid & d_md_op & md_busy;
    assign stall         = (|src_hazard) | md_hazard;
    assign e_flush       = stall;
    assign md_issue      = d_valid & d_md_start & ~stall & ~flush;
    assign stall_timeout = timeout_q | (stall_cnt == SCW'(STALL_LIMIT));

    // -----------------------------------------------------------------------
    // State: scoreboard shift, MDU counter, stall watchdog
    // -----------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, which is what makes the shift register shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the scoreboard is a handful of flops, not a RAM, so every
            // field is reset; only the valid bits matter functionally.
            ent_valid <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                ent_addr[k] <= '0;
                ent_tnew[k] <= '0;
            end
            md_cnt    <= '0;
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            // Entry 0 takes the D instruction, or a bubble when stalled.
            ent_valid[0] <= d_valid & d_wr_en & ~stall & ~flush;
            ent_addr[0]  <= d_wr_addr;
            ent_tnew[0]  <= d_tnew;
            // Older stages always advance; the oldest entry simply drops off.
            for (int k = 1; k < NUM_STAGES; k++) begin
                ent_valid[k] <= ent_valid[k-1] & ~flush;
                ent_addr[k]  <= ent_addr[k-1];
                ent_tnew[k]  <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TW'(1);
            end

            // MDU busy counter; a flush does not cancel an issued operation.
            if (md_issue) begin
                md_cnt <= d_md_div ? MDW'(DIV_CYCLES) : MDW'(MULT_CYCLES);
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - MDW'(1);
            end

            // Consecutive-stall watchdog.
            if (flush || !stall) begin
                stall_cnt <= '0;
            end else if (stall_cnt != SCW'(STALL_LIMIT)) begin
                stall_cnt <= stall_cnt + SCW'(1);
            end
            timeout_q <= timeout_q | (stall_cnt == SCW'(STALL_LIMIT));
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard. Four scoreboard stages are used so a
// single load with an inflated Tnew can hold the stall for four cycles and
// trip a watchdog configured with STALL_LIMIT = 4.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int REG_AW      = 5;
    localparam int NUM_STAGES  = 4;
    localparam int NUM_SRC     = 2;
    localparam int TW          = 3;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;
    localparam int STALL_LIMIT = 4;

    logic                      clk;
    logic                      reset;
    logic                      flush;
    logic                      d_valid;
    logic [NUM_SRC*REG_AW-1:0] d_src_addr;
    logic [NUM_SRC-1:0]        d_src_use;
    logic [NUM_SRC*TW-1:0]     d_src_tuse;
    logic                      d_wr_en;
    logic [REG_AW-1:0]         d_wr_addr;
    logic [TW-1:0]             d_tnew;
    logic                      d_md_op;
    logic                      d_md_start;
    logic                      d_md_div;
    logic                      stall;
    logic                      e_flush;
    logic [NUM_SRC*3-1:0]      fwd_sel;
    logic                      md_busy;
    logic                      stall_timeout;

    int vecs;
    int errs;

    hazard_scoreboard #(
        .REG_AW      (REG_AW),
        .NUM_STAGES  (NUM_STAGES),
        .NUM_SRC     (NUM_SRC),
        .TW          (TW),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .d_valid       (d_valid),
        .d_src_addr    (d_src_addr),
        .d_src_use     (d_src_use),
        .d_src_tuse    (d_src_tuse),
        .d_wr_en       (d_wr_en),
        .d_wr_addr     (d_wr_addr),
        .d_tnew        (d_tnew),
        .d_md_op       (d_md_op),
        .d_md_start    (d_md_start),
        .d_md_div      (d_md_div),
        .stall         (stall),
        .e_flush       (e_flush),
        .fwd_sel       (fwd_sel),
        .md_busy       (md_busy),
        .stall_timeout (stall_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stimulus helpers (no checking here) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_d();
        flush      = 1'b0;
        d_valid    = 1'b0;
        d_src_addr = '0;
        d_src_use  = '0;
        d_src_tuse = '0;
        d_wr_en    = 1'b0;
        d_wr_addr  = '0;
        d_tnew     = '0;
        d_md_op    = 1'b0;
        d_md_start = 1'b0;
        d_md_div   = 1'b0;
    endtask

    task automatic drain();
        idle_d();
        for (int n = 0; n < NUM_STAGES + 1; n++) tick();
    endtask

    // D holds a pure writer (no sources read).
    task automatic d_writer(input logic [REG_AW-1:0] a, input logic [TW-1:0] t);
        idle_d();
        d_valid   = 1'b1;
        d_wr_en   = 1'b1;
        d_wr_addr = a;
        d_tnew    = t;
    endtask

    // D holds a reader of one operand slot (no write).
    task automatic d_reader(input int slot, input logic [REG_AW-1:0] a, input logic [TW-1:0] tuse);
        idle_d();
        d_valid                       = 1'b1;
        d_src_addr[slot*REG_AW +: REG_AW] = a;
        d_src_use[slot]               = 1'b1;
        d_src_tuse[slot*TW +: TW]     = tuse;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_d();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        vecs++;
        if ({stall, e_flush, md_busy, stall_timeout} !== 4'b0000) begin
            $display("FAIL reset_flags: stall/e_flush/md_busy/timeout=%b expected 0000",
                     {stall, e_flush, md_busy, stall_timeout});
            errs++;
        end
        // Empty scoreboard: a reader of $2 must go to the GRF with no stall.
        d_reader(0, 5'd2, 3'd0);
        #1;
        vecs++;
        if (fwd_sel !== 6'd0 || stall !== 1'b0) begin
            $display("FAIL reset_empty: fwd_sel=%0h stall=%b expected 0/0", fwd_sel, stall);
            errs++;
        end
        idle_d();
    endtask

    task automatic test_load_use();
        d_writer(5'd2, 3'd2);              // lw $2
        #1;
        vecs++;
        if (stall !== 1'b0) begin
            $display("FAIL lu_issue: stall=%b expected 0", stall);
            errs++;
        end
        tick();
        d_reader(0, 5'd2, 3'd0);           // beq $2,$0
        d_src_use[1] = 1'b1;               // rt = $0 is read too
        for (int c = 1; c <= 2; c++) begin
            #1;
            vecs++;
            if (stall !== 1'b1 || e_flush !== 1'b1 || fwd_sel !== 6'd0) begin
                $display("FAIL lu_stall%0d: stall=%b e_flush=%b fwd_sel=%0h expected 1/1/0",
                         c, stall, e_flush, fwd_sel);
                errs++;
            end
            tick();
        end
        #1;
        vecs++;
        if (stall !== 1'b0 || fwd_sel[2:0] !== 3'd3 || fwd_sel[5:3] !== 3'd0) begin
            $display("FAIL lu_fwd_w: stall=%b fwd0=%0d fwd1=%0d expected 0/3/0",
                     stall, fwd_sel[2:0], fwd_sel[5:3]);
            errs++;
        end
        tick();
        drain();
    endtask

    task automatic test_alu_use();
        d_writer(5'd3, 3'd1);              // addu $3
        tick();
        d_reader(0, 5'd3, 3'd0);           // beq $3
        #1;
        vecs++;
        if (stall !== 1'b1) begin
            $display("FAIL alu_stall: stall=%b expected 1", stall);
            errs++;
        end
        tick();
        vecs++;
        if (stall !== 1'b0 || fwd_sel[2:0] !== 3'd2) begin
            $display("FAIL alu_fwd_m: stall=%b fwd0=%0d expected 0/2", stall, fwd_sel[2:0]);
            errs++;
        end
        tick();
        drain();
    endtask

    task automatic test_back_to_back();
        d_writer(5'd4, 3'd0);              // addu $4 (older)
        tick();
        d_writer(5'd4, 3'd0);              // addu $4 (younger)
        tick();
        d_reader(1, 5'd4, 3'd1);           // reader of $4 in rt slot
        #1;
        vecs++;
        if (stall !== 1'b0 || fwd_sel[5:3] !== 3'd1 || fwd_sel[2:0] !== 3'd0) begin
            $display("FAIL b2b_youngest: stall=%b fwd1=%0d fwd0=%0d expected 0/1/0",
                     stall, fwd_sel[5:3], fwd_sel[2:0]);
            errs++;
        end
        tick();
        drain();
    endtask

    task automatic test_zero_and_late();
        // Writer to $0 never creates a hazard.
        d_writer(5'd0, 3'd2);
        tick();
        d_reader(0, 5'd0, 3'd0);
        #1;
        vecs++;
        if (stall !== 1'b0 || fwd_sel !== 6'd0) begin
            $display("FAIL zero_reg: stall=%b fwd_sel=%0h expected 0/0", stall, fwd_sel);
            errs++;
        end
        tick();
        drain();
        // tuse == tnew: no stall, later stage forwards.
        d_writer(5'd5, 3'd2);
        tick();
        d_reader(0, 5'd5, 3'd2);
        #1;
        vecs++;
        if (stall !== 1'b0 || fwd_sel[2:0] !== 3'd0) begin
            $display("FAIL tuse_eq_tnew: stall=%b fwd0=%0d expected 0/0", stall, fwd_sel[2:0]);
            errs++;
        end
        // Same operand marked unused: still no stall, GRF.
        d_src_tuse = '0;
        d_src_use  = '0;
        #1;
        vecs++;
        if (stall !== 1'b0 || fwd_sel !== 6'd0) begin
            $display("FAIL src_unused: stall=%b fwd_sel=%0h expected 0/0", stall, fwd_sel);
            errs++;
        end
        tick();
        drain();
    endtask

    task automatic test_watchdog_flush();
        #1;
        vecs++;
        if (stall_timeout !== 1'b0) begin
            $display("FAIL wd_clear: stall_timeout=%b expected 0", stall_timeout);
            errs++;
        end
        d_writer(5'd7, 3'd7);              // lw $7, artificial tnew 7
        tick();
        d_reader(0, 5'd7, 3'd0);
        for (int c = 1; c <= 4; c++) begin
            #1;
            vecs++;
            if (stall !== 1'b1 || stall_timeout !== 1'b0) begin
                $display("FAIL wd_stall%0d: stall=%b timeout=%b expected 1/0", c, stall, stall_timeout);
                errs++;
            end
            tick();
        end
        vecs++;
        if (stall !== 1'b0 || stall_timeout !== 1'b1) begin
            $display("FAIL wd_trip: stall=%b timeout=%b expected 0/1", stall, stall_timeout);
            errs++;
        end
        tick();
        tick();
        vecs++;
        if (stall_timeout !== 1'b1) begin
            $display("FAIL wd_sticky: stall_timeout=%b expected 1", stall_timeout);
            errs++;
        end
        // Flush clears a pending hazard.
        d_writer(5'd8, 3'd7);
        tick();
        d_reader(0, 5'd8, 3'd0);
        #1;
        vecs++;
        if (stall !== 1'b1) begin
            $display("FAIL fl_pre: stall=%b expected 1", stall);
            errs++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        vecs++;
        if (stall !== 1'b0 || e_flush !== 1'b0 || fwd_sel !== 6'd0) begin
            $display("FAIL fl_clear: stall=%b e_flush=%b fwd_sel=%0h expected 0/0/0",
                     stall, e_flush, fwd_sel);
            errs++;
        end
        tick();
        drain();
    endtask

    task automatic test_mdu_div();
        idle_d();
        d_valid    = 1'b1;
        d_md_op    = 1'b1;
        d_md_start = 1'b1;
        d_md_div   = 1'b1;
        #1;
        vecs++;
        if (stall !== 1'b0 || md_busy !== 1'b0) begin
            $display("FAIL div_issue: stall=%b md_busy=%b expected 0/0", stall, md_busy);
            errs++;
        end
        tick();
        d_md_start = 1'b0;                 // mflo
        d_md_div   = 1'b0;
        for (int c = 1; c <= DIV_CYCLES; c++) begin
            vecs++;
            if (stall !== 1'b1 || md_busy !== 1'b1) begin
                $display("FAIL div_busy%0d: stall=%b md_busy=%b expected 1/1", c, stall, md_busy);
                errs++;
            end
            tick();
        end
        vecs++;
        if (stall !== 1'b0 || md_busy !== 1'b0) begin
            $display("FAIL div_done: stall=%b md_busy=%b expected 0/0", stall, md_busy);
            errs++;
        end
        tick();
        idle_d();
    endtask

    task automatic test_mdu_mult_back_to_back();
        idle_d();
        d_valid    = 1'b1;
        d_md_op    = 1'b1;
        d_md_start = 1'b1;                 // mult
        tick();
        // Second mult waits out the first.
        for (int c = 1; c <= MULT_CYCLES; c++) begin
            vecs++;
            if (stall !== 1'b1) begin
                $display("FAIL mult_wait%0d: stall=%b expected 1", c, stall);
                errs++;
            end
            tick();
        end
        vecs++;
        if (stall !== 1'b0 || md_busy !== 1'b0) begin
            $display("FAIL mult_issue2: stall=%b md_busy=%b expected 0/0", stall, md_busy);
            errs++;
        end
        tick();
        idle_d();
        vecs++;
        if (md_busy !== 1'b1) begin
            $display("FAIL mult_reload: md_busy=%b expected 1", md_busy);
            errs++;
        end
        for (int n = 0; n < MULT_CYCLES; n++) tick();
        vecs++;
        if (md_busy !== 1'b0) begin
            $display("FAIL mult_expire: md_busy=%b expected 0", md_busy);
            errs++;
        end
    endtask

    task automatic test_reset_mid_div();
        idle_d();
        d_valid    = 1'b1;
        d_md_op    = 1'b1;
        d_md_start = 1'b1;
        d_md_div   = 1'b1;
        tick();
        idle_d();
        flush = 1'b1;                      // flush must not cancel the MDU
        tick();
        flush = 1'b0;
        tick();
        vecs++;
        if (md_busy !== 1'b1) begin
            $display("FAIL rst_pre: md_busy=%b expected 1", md_busy);
            errs++;
        end
        #2;
        reset = 1'b0;
        #1;
        vecs++;
        if (md_busy !== 1'b0 || stall_timeout !== 1'b0 || stall !== 1'b0) begin
            $display("FAIL rst_async: md_busy=%b timeout=%b stall=%b expected 0/0/0",
                     md_busy, stall_timeout, stall);
            errs++;
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        vecs  = 0;
        errs  = 0;
        reset = 1'b1;
        idle_d();
        test_reset();
        test_load_use();
        test_alu_use();
        test_back_to_back();
        test_zero_and_late();
        test_watchdog_flush();
        test_mdu_div();
        test_mdu_mult_back_to_back();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
